// File: rtl/reg_dump_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_uart_tx
//  Purpose  : Register-dump engine for the miniRISC debug port. On start it
//             sweeps reg_addr over 0..NUM_REGS-1. For each register it
//             captures reg_data and sends three UART 8N1 bytes:
//             {index}, data[15:8], data[7:0].
//  Ports    : clk      - system clock, rising edge
//             rst      - synchronous active-high reset
//             start    - dump request, sampled only while idle
//             reg_addr - register select to the core (registered)
//             reg_data - selected register value from the core
//             tx       - UART serial output, idles high (registered)
//             busy     - dump in progress (registered)
//             done     - one-cycle completion pulse (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0]   c_IDX_LAST  = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]          c_BIT_STOP  = 4'd9;
    localparam logic [1:0]          c_BYTE_LAST = 2'd2;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;

    logic [1:0]          r_state,    w_state_nxt;
    logic [ADDR_W-1:0]   r_idx,      w_idx_nxt;
    logic [DATA_W-1:0]   r_cap,      w_cap_nxt;
    logic [1:0]          r_byte_sel, w_byte_sel_nxt;
    logic [3:0]          r_bit_cnt,  w_bit_cnt_nxt;
    logic [c_BAUD_W-1:0] r_baud,     w_baud_nxt;
    logic                r_tx,       w_tx_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_done,     w_done_nxt;
    logic [7:0]          w_cur_byte;

    // The index doubles as reg_addr; it is forced to 0 whenever the engine
    // is idle, so reg_addr needs no separate register.
    assign reg_addr = r_idx;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

    // Byte currently being framed.
    always_comb begin
        w_cur_byte = 8'h00;
        case (r_byte_sel)
            2'd0:    w_cur_byte = 8'(r_idx);
            2'd1:    w_cur_byte = r_cap[15:8];
            default: w_cur_byte = r_cap[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= '0;
            r_cap      <= '0;
            r_byte_sel <= '0;
            r_bit_cnt  <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cap      <= w_cap_nxt;
            r_byte_sel <= w_byte_sel_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud     <= w_baud_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // tx is registered, so each transition computes the level of the bit
    // that will be on the line during the following cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cap_nxt      = r_cap;
        w_byte_sel_nxt = r_byte_sel;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_baud_nxt     = r_baud;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_idx_nxt  = '0;
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = c_ST_SETUP;
                    w_busy_nxt  = 1'b1;
                end
            end

            // reg_addr has been stable for a full cycle; capture and
            // launch the start bit of the index byte.
            c_ST_SETUP: begin
                w_cap_nxt      = reg_data;
                w_byte_sel_nxt = 2'd0;
                w_bit_cnt_nxt  = 4'd0;
                w_baud_nxt     = '0;
                w_tx_nxt       = 1'b0;
                w_state_nxt    = c_ST_SEND;
            end

            c_ST_SEND: begin
                if (r_baud != c_BAUD_LAST) begin
                    w_baud_nxt = r_baud + 1'b1;
                end else begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt != c_BIT_STOP) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        // Bit counts 0..7 are followed by data bit r_bit_cnt;
                        // count 8 is followed by the stop bit.
                        if (r_bit_cnt == 4'd8) begin
                            w_tx_nxt = 1'b1;
                        end else begin
                            w_tx_nxt = w_cur_byte[r_bit_cnt[2:0]];
                        end
                    end else begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_byte_sel != c_BYTE_LAST) begin
                            // Next byte starts immediately, no idle gap.
                            w_byte_sel_nxt = r_byte_sel + 2'd1;
                            w_tx_nxt       = 1'b0;
                        end else begin
                            w_byte_sel_nxt = 2'd0;
                            w_tx_nxt       = 1'b1;
                            if (r_idx != c_IDX_LAST) begin
                                w_idx_nxt   = r_idx + 1'b1;
                                w_state_nxt = c_ST_SETUP;
                            end else begin
                                w_idx_nxt   = '0;
                                w_busy_nxt  = 1'b0;
                                w_done_nxt  = 1'b1;
                                w_state_nxt = c_ST_IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_idx_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
